// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the serial-load shift register sequencer.
// Holds the controller state encoding, the default register width and the
// width of the bit counter that walks the serial load.
package shift_ctrl_pkg;

    localparam int N_BITS_DEF = 8;
    localparam int CNT_W      = $clog2(N_BITS_DEF);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        INVERT = 2'd2,
        RESULT = 2'd3
    } state_t;

    // Bit-counter width for an arbitrary register width (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shift_reg_ctrl_rr_arb2.sv
// Two-way round-robin arbiter with a registered last-grant.
// Ports:
//   clock  - system clock, rising edge
//   reset  - synchronous active-high reset; last-grant returns to requester 1
//   valid  - request pair, bit i = requester i
//   accept - a grant was taken this cycle; updates last-grant
//   grant  - one-hot grant (all zero when nobody requests)
module rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);

    // 1 = requester 1 was granted last, so requester 0 wins the next tie.
    logic last_reg;

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = last_reg ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_reg <= 1'b1;
        end else if (accept && (grant != 2'b00)) begin
            last_reg <= grant[1];
        end
    end

endmodule

// File: rtl/shift_reg_ctrl.sv
// Sequencer/arbiter for an N_BITS serial-load shift register.
// Two requesters offer bytes; the round-robin winner's byte is shifted into
// the register LSB-first, optionally followed by one invert cycle, then the
// parallel contents are captured, compared and returned.
// Ports:
//   clock, reset               - clock and synchronous active-high reset
//   req_valid0/1, req_data0/1  - byte-load requests
//   req_inv0/1                 - request one invert cycle after the load
//   req_ready0/1               - grant, only in IDLE and only to the winner
//   sr_wejscie, sr_functional  - serial bit and mode to the shift register
//   sr_wyjscie                 - parallel contents of the shift register
//   out_valid/data/src/err     - one-cycle result strobe and its payload
//   err_cnt                    - saturating mismatch counter
//   busy                       - controller is not in IDLE
module shift_reg_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int N_BITS     = N_BITS_DEF,
    parameter int INV_ENABLE = 1,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid0,
    input  logic                 req_valid1,
    input  logic [N_BITS-1:0]    req_data0,
    input  logic [N_BITS-1:0]    req_data1,
    input  logic                 req_inv0,
    input  logic                 req_inv1,
    output logic                 req_ready0,
    output logic                 req_ready1,
    output logic                 sr_wejscie,
    output logic                 sr_functional,
    input  logic [N_BITS-1:0]    sr_wyjscie,
    output logic                 out_valid,
    output logic [N_BITS-1:0]    out_data,
    output logic                 out_src,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 busy
);

    localparam int             K_W    = cnt_width(N_BITS);
    localparam logic [K_W-1:0] K_LAST = K_W'(N_BITS - 1);
    localparam logic           INV_EN = (INV_ENABLE != 0);

    state_t state_reg, state_next;

    logic [K_W-1:0]       k_reg;
    logic [N_BITS-1:0]    data_reg;
    logic                 inv_reg;
    logic                 src_reg;

    logic                 out_valid_reg;
    logic [N_BITS-1:0]    out_data_reg;
    logic                 out_src_reg;
    logic                 out_err_reg;
    logic [ERR_CNT_W-1:0] err_cnt_reg;

    logic [1:0]           valid_vec;
    logic [1:0]           grant_vec;
    logic [1:0]           ready_vec;
    logic                 accept;
    logic [N_BITS-1:0]    exp_val;
    logic                 mismatch;

    assign valid_vec = {req_valid1, req_valid0};

    rr_arb2 u_arb (
        .clock  (clock),
        .reset  (reset),
        .valid  (valid_vec),
        .accept (accept),
        .grant  (grant_vec)
    );

    // Ready is combinational: only the arbiter winner, only while idle,
    // and never while reset is being applied.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign ready_vec[gi] = grant_vec[gi] && (state_reg == IDLE) && !reset;
        end
    endgenerate

    assign req_ready0 = ready_vec[0];
    assign req_ready1 = ready_vec[1];
    assign accept     = |(valid_vec & ready_vec);

    // ---------------- state register ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = LOAD;
            LOAD:    if (k_reg == K_LAST) state_next = inv_reg ? INVERT : RESULT;
            INVERT:  state_next = RESULT;
            RESULT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    // Every non-LOAD cycle drives functional=0, which toggles the register
    // and parks its bit pointer at 0 so the next load starts aligned.
    always_comb begin
        sr_functional = 1'b0;
        sr_wejscie    = 1'b0;
        busy          = (state_reg != IDLE);
        if (!reset && (state_reg == LOAD)) begin
            sr_functional = 1'b1;
            sr_wejscie    = data_reg[k_reg];
        end
    end

    // ---------------- transaction datapath ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            k_reg    <= '0;
            data_reg <= '0;
            inv_reg  <= 1'b0;
            src_reg  <= 1'b0;
        end else if ((state_reg == IDLE) && accept) begin
            k_reg    <= '0;
            data_reg <= grant_vec[1] ? req_data1 : req_data0;
            inv_reg  <= (grant_vec[1] ? req_inv1 : req_inv0) && INV_EN;
            src_reg  <= grant_vec[1];
        end else if (state_reg == LOAD) begin
            k_reg    <= k_reg + K_W'(1);
        end
    end

    // After an invert cycle the register holds the complement of the load.
    assign exp_val  = inv_reg ? ~data_reg : data_reg;
    assign mismatch = (sr_wyjscie != exp_val);

    // ---------------- result capture and checker ----------------
    // The capture uses the value seen before the RESULT closing edge; that
    // edge itself inverts the register again, which is harmless.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_src_reg   <= 1'b0;
            out_err_reg   <= 1'b0;
            err_cnt_reg   <= '0;
        end else begin
            out_valid_reg <= (state_reg == RESULT);
            if (state_reg == RESULT) begin
                out_data_reg <= sr_wyjscie;
                out_src_reg  <= src_reg;
                out_err_reg  <= mismatch;
                if (mismatch && (err_cnt_reg != '1)) begin
                    err_cnt_reg <= err_cnt_reg + ERR_CNT_W'(1);
                end
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_src   = out_src_reg;
    assign out_err   = out_err_reg;
    assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_shift_reg_ctrl.sv
module tb_shift_reg_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // DUT A: invert enabled
    logic       rv0, rv1, ri0, ri1, rr0, rr1;
    logic [7:0] rd0, rd1;
    logic       sr_in, sr_fn, ov, os, oe, busy;
    logic [7:0] sr_q, od, ec;

    // DUT B: invert disabled
    logic       b_rv0, b_rv1, b_ri0, b_ri1, b_rr0, b_rr1;
    logic [7:0] b_rd0, b_rd1;
    logic       b_sr_in, b_sr_fn, b_ov, b_os, b_oe, b_busy;
    logic [7:0] b_sr_q, b_od, b_ec;

    shift_reg_ctrl #(.N_BITS(8), .INV_ENABLE(1), .ERR_CNT_W(8)) dut_a (
        .clock(clock), .reset(reset),
        .req_valid0(rv0), .req_valid1(rv1), .req_data0(rd0), .req_data1(rd1),
        .req_inv0(ri0), .req_inv1(ri1), .req_ready0(rr0), .req_ready1(rr1),
        .sr_wejscie(sr_in), .sr_functional(sr_fn), .sr_wyjscie(sr_q),
        .out_valid(ov), .out_data(od), .out_src(os), .out_err(oe),
        .err_cnt(ec), .busy(busy)
    );

    shift_reg_ctrl #(.N_BITS(8), .INV_ENABLE(0), .ERR_CNT_W(8)) dut_b (
        .clock(clock), .reset(reset),
        .req_valid0(b_rv0), .req_valid1(b_rv1), .req_data0(b_rd0), .req_data1(b_rd1),
        .req_inv0(b_ri0), .req_inv1(b_ri1), .req_ready0(b_rr0), .req_ready1(b_rr1),
        .sr_wejscie(b_sr_in), .sr_functional(b_sr_fn), .sr_wyjscie(b_sr_q),
        .out_valid(b_ov), .out_data(b_od), .out_src(b_os), .out_err(b_oe),
        .err_cnt(b_ec), .busy(b_busy)
    );

    // Behavioural shift register models: load bit at pointer, or invert+clear.
    logic [7:0] a_reg = 8'h00, b_reg = 8'h00;
    logic [2:0] a_ptr = 3'd0,  b_ptr = 3'd0;
    logic       stuck0 = 1'b0;

    always @(posedge clock) begin
        if (sr_fn) begin a_reg[a_ptr] <= sr_in; a_ptr <= a_ptr + 3'd1; end
        else       begin a_reg <= ~a_reg;       a_ptr <= 3'd0;         end
        if (b_sr_fn) begin b_reg[b_ptr] <= b_sr_in; b_ptr <= b_ptr + 3'd1; end
        else         begin b_reg <= ~b_reg;         b_ptr <= 3'd0;         end
    end
    assign sr_q   = stuck0 ? (a_reg & 8'hFE) : a_reg;
    assign b_sr_q = b_reg;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_pass = 0, n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [7:0] data;
        logic       src;
        logic       err;
        int         cyc;
    } exp_t;

    exp_t q_a[$], q_b[$];
    int   acc_src_a[$];
    int   n_acc_a = 0, n_out_a = 0, n_acc_b = 0, n_out_b = 0, acc_cyc_a = -1;
    logic [7:0] last_od_a = 8'h00, last_od_b = 8'h00;

    task automatic push_a(input logic s, input logic [7:0] d, input logic inv);
        exp_t e;
        logic [7:0] base;
        base   = inv ? ~d : d;
        e.data = stuck0 ? (base & 8'hFE) : base;
        e.err  = (e.data != base);
        e.src  = s;
        e.cyc  = cyc + (inv ? 11 : 10);
        q_a.push_back(e);
        acc_src_a.push_back(s ? 1 : 0);
        acc_cyc_a = cyc;
        n_acc_a++;
    endtask

    task automatic push_b(input logic s, input logic [7:0] d);
        exp_t e;
        e.data = d;
        e.err  = 1'b0;
        e.src  = s;
        e.cyc  = cyc + 10;
        q_b.push_back(e);
        n_acc_b++;
    endtask

    always @(negedge clock) begin
        exp_t e;
        logic exp_ov;
        if (reset) begin
            q_a.delete();
            q_b.delete();
        end else begin
            if (rv0 && rr0) push_a(1'b0, rd0, ri0);
            if (rv1 && rr1) push_a(1'b1, rd1, ri1);
            if (b_rv0 && b_rr0) push_b(1'b0, b_rd0);
            if (b_rv1 && b_rr1) push_b(1'b1, b_rd1);

            exp_ov = (q_a.size() > 0) && (q_a[0].cyc == cyc);
            if (ov || exp_ov) begin
                chk("a_out_valid", 32'(ov), 32'(exp_ov));
                if (q_a.size() > 0) begin
                    e = q_a.pop_front();
                    if (ov) begin
                        chk("a_out_data", 32'(od), 32'(e.data));
                        chk("a_out_src",  32'(os), 32'(e.src));
                        chk("a_out_err",  32'(oe), 32'(e.err));
                    end
                end
            end
            if (ov) begin n_out_a++; last_od_a = od; end

            exp_ov = (q_b.size() > 0) && (q_b[0].cyc == cyc);
            if (b_ov || exp_ov) begin
                chk("b_out_valid", 32'(b_ov), 32'(exp_ov));
                if (q_b.size() > 0) begin
                    e = q_b.pop_front();
                    if (b_ov) begin
                        chk("b_out_data", 32'(b_od), 32'(e.data));
                        chk("b_out_src",  32'(b_os), 32'(e.src));
                        chk("b_out_err",  32'(b_oe), 32'(e.err));
                    end
                end
            end
            if (b_ov) begin n_out_b++; last_od_b = b_od; end
        end
    end

    function automatic int cnt_of(input int which);
        case (which)
            0: return n_acc_a;
            1: return n_out_a;
            2: return n_acc_b;
            default: return n_out_b;
        endcase
    endfunction

    // Bounded wait on a scoreboard counter; returns #1 after a rising edge.
    task automatic wait_for(input int which, input int target, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(posedge clock);
            if (cnt_of(which) >= target) break;
        end
        chk(name, 32'(cnt_of(which)), 32'(target));
        #1;
    endtask

    task automatic txn_a(input logic s, input logic [7:0] d, input logic inv);
        int at, ot;
        at = n_acc_a + 1;
        ot = n_out_a + 1;
        if (s) begin rv1 = 1'b1; rd1 = d; ri1 = inv; end
        else   begin rv0 = 1'b1; rd0 = d; ri0 = inv; end
        wait_for(0, at, 40, "a_accept");
        rv0 = 1'b0; rv1 = 1'b0;
        wait_for(1, ot, 40, "a_result");
    endtask

    typedef struct {
        logic       src;
        logic [7:0] data;
        logic       inv;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int base, ot;
        logic [7:0] a5;

        vecs[0] = '{1'b1, 8'h3C, 1'b1, 8'hC3};
        vecs[1] = '{1'b0, 8'h81, 1'b1, 8'h7E};
        vecs[2] = '{1'b1, 8'h00, 1'b1, 8'hFF};
        vecs[3] = '{1'b0, 8'hFF, 1'b0, 8'hFF};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 8'h00};
        vecs[5] = '{1'b1, 8'h5A, 1'b0, 8'h5A};

        rv0 = 1'b1; rd0 = 8'hA5; ri0 = 1'b0;
        rv1 = 1'b0; rd1 = 8'h00; ri1 = 1'b0;
        b_rv0 = 1'b0; b_rd0 = 8'h00; b_ri0 = 1'b0;
        b_rv1 = 1'b0; b_rd1 = 8'h00; b_ri1 = 1'b0;

        // Reset state, with a request already waiting.
        repeat (3) @(negedge clock);
        chk("rst_ready0", 32'(rr0), 32'd0);
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_sr_fn",  32'(sr_fn), 32'd0);
        chk("rst_out_valid", 32'(ov), 32'd0);
        chk("rst_out_data",  32'(od), 32'd0);
        chk("rst_err_cnt",   32'(ec), 32'd0);

        // 0xA5 accepted in the first IDLE cycle, then serial bits LSB first.
        @(posedge clock); #1 reset = 1'b0;
        base = cyc;
        ot = n_out_a + 1;
        wait_for(0, 1, 40, "a5_accept");
        chk("a5_first_idle_accept", 32'(acc_cyc_a), 32'(base));
        rv0 = 1'b0;
        a5 = 8'hA5;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            chk("a5_sr_functional", 32'(sr_fn), 32'd1);
            chk("a5_sr_wejscie",    32'(sr_in), 32'(a5[k]));
        end
        @(negedge clock);
        chk("a5_result_sr_fn", 32'(sr_fn), 32'd0);
        wait_for(1, ot, 40, "a5_result");
        chk("a5_table_data", 32'(last_od_a), 32'hA5);

        // Table-driven single transactions (last entry leaves last-grant=1).
        for (int i = 0; i < 6; i++) begin
            txn_a(vecs[i].src, vecs[i].data, vecs[i].inv);
            chk($sformatf("vec%0d_data", i), 32'(last_od_a), 32'(vecs[i].exp_data));
        end

        // Both requesters held valid: grants alternate starting with 0.
        base = n_acc_a;
        ot = n_out_a + 4;
        rv0 = 1'b1; rd0 = 8'h11; ri0 = 1'b0;
        rv1 = 1'b1; rd1 = 8'h22; ri1 = 1'b0;
        wait_for(0, base + 4, 80, "rr_accepts");
        rv0 = 1'b0; rv1 = 1'b0;
        wait_for(1, ot, 40, "rr_results");
        for (int i = 0; i < 4; i++) begin
            if (base + i < acc_src_a.size())
                chk($sformatf("rr_grant%0d", i), 32'(acc_src_a[base + i]), 32'(i % 2));
        end

        // Reset in the 4th LOAD cycle of 0xFF discards the transaction.
        rv0 = 1'b1; rd0 = 8'hFF; ri0 = 1'b0;
        wait_for(0, n_acc_a + 1, 40, "rst_mid_accept");
        rv0 = 1'b0;
        ot = n_out_a;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_mid_busy",  32'(busy), 32'd0);
        chk("rst_mid_sr_fn", 32'(sr_fn), 32'd0);
        repeat (15) @(posedge clock);
        chk("rst_mid_no_out", 32'(n_out_a), 32'(ot));
        #1;
        txn_a(1'b0, 8'h0F, 1'b0);
        chk("rst_mid_after_data", 32'(last_od_a), 32'h0F);

        // Stuck-at-0 on register bit 0: mismatch and saturating counter.
        stuck0 = 1'b1;
        txn_a(1'b0, 8'hFF, 1'b0);
        chk("stuck_data", 32'(last_od_a), 32'hFE);
        chk("stuck_err",  32'(oe), 32'd1);
        chk("stuck_cnt1", 32'(ec), 32'd1);
        ot = n_out_a + 299;
        rv0 = 1'b1; rd0 = 8'hFF; ri0 = 1'b0;
        wait_for(0, n_acc_a + 299, 3300, "stuck_accepts");
        rv0 = 1'b0;
        wait_for(1, ot, 40, "stuck_results");
        chk("stuck_cnt_sat", 32'(ec), 32'd255);
        stuck0 = 1'b0;

        // Invert disabled: req_inv ignored, result at accept+10.
        b_rv0 = 1'b1; b_rd0 = 8'h5A; b_ri0 = 1'b1;
        wait_for(2, 1, 40, "b_accept");
        b_rv0 = 1'b0;
        wait_for(3, 1, 40, "b_result");
        chk("b_data", 32'(last_od_b), 32'h5A);
        chk("b_busy_after", 32'(b_busy), 32'd0);
        chk("b_err_cnt", 32'(b_ec), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
